idu_decode_queue: RTL and testbench

- Parametrised decode stage between IFU and EXU.
- Buffers fetched instructions in a DEPTH-entry FIFO and decodes the head entry into sign-extended immediate and control fields.
- Holds the head via a per-register scoreboard until its source operands have no pending writes (RAW interlock).
- Valid/ready handshake on both sides; flush and scoreboard-clear support branch/trap recovery.

---
 rtl/idu_decode_queue.sv | 250 +++++++++++++++++++++++++
 tb/tb_idu_decode_queue.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/idu_decode_queue.sv
// Decode stage: DEPTH-entry instruction FIFO, RV32I head decode and a per-register
// pending-write scoreboard. Define IDU_BYPASS_EN to let an empty queue present in_* the same cycle.
module idu_decode_queue #(
    parameter int XLEN     = 32,
    parameter int DEPTH    = 2,
    parameter int NREG     = 32,
    parameter int SB_CNT_W = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [31:0]             in_inst,
    input  logic [XLEN-1:0]         in_pc,
    input  logic                    flush,
    input  logic                    sb_clear,
    input  logic                    wb_valid,
    input  logic [4:0]              wb_rd,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [31:0]             out_inst,
    output logic [XLEN-1:0]         out_pc,
    output logic [4:0]              out_rs1,
    output logic [4:0]              out_rs2,
    output logic [4:0]              out_rd,
    output logic [XLEN-1:0]         out_imm,
    output logic [2:0]              out_imm_type,
    output logic                    out_rd_wen,
    output logic                    out_mem_ren,
    output logic                    out_mem_wen,
    output logic                    out_branch,
    output logic                    out_jump,
    output logic                    out_ecall,
    output logic                    out_mret,
    output logic                    out_illegal,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]    FULL_CNT = CNT_W'(DEPTH);
    localparam logic [SB_CNT_W-1:0] SB_MAX   = '1;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_type_e;

    logic [31:0]         inst_mem_q [DEPTH];
    logic [31:0]         inst_mem_d [DEPTH];
    logic [XLEN-1:0]     pc_mem_q   [DEPTH];
    logic [XLEN-1:0]     pc_mem_d   [DEPTH];
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [SB_CNT_W-1:0] sb_q [NREG];
    logic [SB_CNT_W-1:0] sb_d [NREG];

    logic            fifo_empty, bypass_sel, head_valid;
    logic [31:0]     head_inst;
    logic [XLEN-1:0] head_pc;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            is_lui, is_auipc, is_jal, is_jalr, is_branch, is_load;
    logic            is_store, is_opimm, is_op, is_fence, is_system;
    logic            rd_wen_raw, rs1_used, rs2_used, bad_idx, hazard;
    logic [31:0]     imm32;
    imm_type_e       imm_type;
    logic [31:0]     sb_busy, sb_full;
    logic            dispatch, push, pop;

    assign fifo_empty = (count_q == '0);
    assign count      = count_q;

    // Head is the oldest queued entry; the bypass build can substitute the incoming word.
    always_comb begin
        bypass_sel = 1'b0;
        head_valid = !fifo_empty;
        head_inst  = fifo_empty ? '0 : inst_mem_q[rd_ptr_q];
        head_pc    = fifo_empty ? '0 : pc_mem_q[rd_ptr_q];
`ifdef IDU_BYPASS_EN
        if (fifo_empty && in_valid && !reset) begin
            bypass_sel = 1'b1;
            head_valid = 1'b1;
            head_inst  = in_inst;
            head_pc    = in_pc;
        end
`endif
    end

    always_comb begin
        opcode    = head_inst[6:0];
        funct3    = head_inst[14:12];
        is_lui    = head_valid && (opcode == OPC_LUI);
        is_auipc  = head_valid && (opcode == OPC_AUIPC);
        is_jal    = head_valid && (opcode == OPC_JAL);
        is_jalr   = head_valid && (opcode == OPC_JALR);
        is_branch = head_valid && (opcode == OPC_BRANCH);
        is_load   = head_valid && (opcode == OPC_LOAD);
        is_store  = head_valid && (opcode == OPC_STORE);
        is_opimm  = head_valid && (opcode == OPC_OPIMM);
        is_op     = head_valid && (opcode == OPC_OP);
        is_fence  = head_valid && (opcode == OPC_FENCE);
        is_system = head_valid && (opcode == OPC_SYSTEM);

        out_inst = head_inst;
        out_pc   = head_pc;
        out_rd   = head_inst[11:7];
        out_rs1  = head_inst[19:15];
        out_rs2  = head_inst[24:20];

        rd_wen_raw = is_lui || is_auipc || is_jal || is_jalr || is_load || is_opimm || is_op
                     || (is_system && funct3 != 3'd0);
        rs1_used   = is_jalr || is_branch || is_load || is_store || is_opimm || is_op
                     || (is_system && (funct3 == 3'd1 || funct3 == 3'd2 || funct3 == 3'd3));
        rs2_used   = is_branch || is_store || is_op;
        bad_idx    = (rs1_used && int'(out_rs1) >= NREG) || (rs2_used && int'(out_rs2) >= NREG)
                     || (rd_wen_raw && int'(out_rd) >= NREG);
        out_illegal = head_valid && (!(is_lui || is_auipc || is_jal || is_jalr || is_branch
                     || is_load || is_store || is_opimm || is_op || is_fence || is_system) || bad_idx);

        out_rd_wen  = rd_wen_raw && (out_rd != 5'd0) && !out_illegal;
        out_mem_ren = is_load && !out_illegal;
        out_mem_wen = is_store && !out_illegal;
        out_branch  = is_branch;
        out_jump    = is_jal || is_jalr;
        out_ecall   = head_valid && (head_inst == 32'h0000_0073);
        out_mret    = head_valid && (head_inst == 32'h3020_0073);

        imm32    = '0;
        imm_type = IMM_NONE;
        if (is_jalr || is_load || is_opimm || is_system) begin
            imm32    = {{20{head_inst[31]}}, head_inst[31:20]};
            imm_type = IMM_I;
        end else if (is_store) begin
            imm32    = {{20{head_inst[31]}}, head_inst[31:25], head_inst[11:7]};
            imm_type = IMM_S;
        end else if (is_branch) begin
            imm32    = {{19{head_inst[31]}}, head_inst[31], head_inst[7], head_inst[30:25],
                        head_inst[11:8], 1'b0};
            imm_type = IMM_B;
        end else if (is_lui || is_auipc) begin
            imm32    = {head_inst[31:12], 12'b0};
            imm_type = IMM_U;
        end else if (is_jal) begin
            imm32    = {{11{head_inst[31]}}, head_inst[31], head_inst[19:12], head_inst[20],
                        head_inst[30:21], 1'b0};
            imm_type = IMM_J;
        end
        out_imm      = XLEN'($signed(imm32));
        out_imm_type = imm_type;
    end

    // Flatten the scoreboard into 32-entry flag vectors so any 5-bit index is safe to look up.
    for (genvar r = 0; r < 32; r++) begin : g_sb_flags
        if (r < NREG) begin : g_real
            assign sb_busy[r] = (sb_q[r] != '0);
            assign sb_full[r] = (sb_q[r] == SB_MAX);
        end else begin : g_none
            assign sb_busy[r] = 1'b0;
            assign sb_full[r] = 1'b0;
        end
    end

    assign hazard    = (rs1_used && out_rs1 != 5'd0 && sb_busy[out_rs1])
                     || (rs2_used && out_rs2 != 5'd0 && sb_busy[out_rs2])
                     || (out_rd_wen && sb_full[out_rd]);
    assign out_valid = head_valid && !hazard && !flush && !reset;
    assign in_ready  = !reset && (count_q != FULL_CNT);
    assign dispatch  = out_valid && out_ready;
    assign push      = in_valid && in_ready && !flush && !(bypass_sel && dispatch);
    assign pop       = dispatch && !bypass_sel;

    always_comb begin
        inst_mem_d = inst_mem_q;
        pc_mem_d   = pc_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                inst_mem_d[wr_ptr_q] = in_inst;
                pc_mem_d[wr_ptr_q]   = in_pc;
                wr_ptr_d             = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    // Dispatch of a writer and its own writeback in one cycle cancel out.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            sb_d[r] = sb_q[r];
            if (sb_clear) begin
                sb_d[r] = '0;
            end else if ((dispatch && out_rd_wen && int'(out_rd) == r)
                         && !(wb_valid && wb_rd != 5'd0 && int'(wb_rd) == r)) begin
                sb_d[r] = sb_q[r] + SB_CNT_W'(1);
            end else if ((wb_valid && wb_rd != 5'd0 && int'(wb_rd) == r)
                         && !(dispatch && out_rd_wen && int'(out_rd) == r)
                         && sb_q[r] != '0) begin
                sb_d[r] = sb_q[r] - SB_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            inst_mem_q <= '{default: '0};
            pc_mem_q   <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            sb_q       <= '{default: '0};
        end else begin
            inst_mem_q <= inst_mem_d;
            pc_mem_q   <= pc_mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            sb_q       <= sb_d;
        end
    end

endmodule

// File: tb/tb_idu_decode_queue.sv
// Directed bench for idu_decode_queue (default build, DEPTH=2, SB_CNT_W=2, NREG=32).
module tb_idu_decode_queue;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_inst = '0;
    logic [31:0] in_pc = '0;
    logic        flush = 1'b0;
    logic        sb_clear = 1'b0;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_inst, out_pc, out_imm;
    logic [4:0]  out_rs1, out_rs2, out_rd;
    logic [2:0]  out_imm_type;
    logic        out_rd_wen, out_mem_ren, out_mem_wen, out_branch, out_jump;
    logic        out_ecall, out_mret, out_illegal;
    logic [1:0]  count;

    int total = 0;
    int bad   = 0;

    idu_decode_queue #(.XLEN(32), .DEPTH(2), .NREG(32), .SB_CNT_W(2)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .flush(flush), .sb_clear(sb_clear), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_imm(out_imm),
        .out_imm_type(out_imm_type), .out_rd_wen(out_rd_wen), .out_mem_ren(out_mem_ren),
        .out_mem_wen(out_mem_wen), .out_branch(out_branch), .out_jump(out_jump),
        .out_ecall(out_ecall), .out_mret(out_mret), .out_illegal(out_illegal),
        .count(count)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        in_valid = 1'b1;
        in_inst  = 32'h0010_0013;
        step();
        step();
        total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_in_ready: got %b want 0", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); end
        reset    = 1'b0;
        in_valid = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL post_reset_in_ready: got %b want 1", in_ready); end
        total++; if (count !== 2'd0) begin bad++; $display("[TB] FAIL post_reset_count: got %0d want 0", count); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL post_reset_out_valid: got %b want 0", out_valid); end
        total++; if (out_inst !== 32'h0 || out_imm !== 32'h0 || out_illegal !== 1'b0 || out_rd_wen !== 1'b0)
            begin bad++; $display("[TB] FAIL empty_outputs: inst=%h imm=%h ill=%b wen=%b want all 0", out_inst, out_imm, out_illegal, out_rd_wen); end
    endtask

    task automatic test_addi();
        in_valid  = 1'b1;
        in_inst   = 32'hFFF0_0093;
        in_pc     = 32'h0000_0100;
        out_ready = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL addi_no_comb_path: got %b want 0", out_valid); end
        step();
        in_valid = 1'b0;
        #1;
        total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL addi_valid: got %b want 1", out_valid); end
        total++; if (out_imm !== 32'hFFFF_FFFF) begin bad++; $display("[TB] FAIL addi_imm: got %h want ffffffff", out_imm); end
        total++; if (out_rd !== 5'd1 || out_rd_wen !== 1'b1) begin bad++; $display("[TB] FAIL addi_rd: got rd=%0d wen=%b want 1/1", out_rd, out_rd_wen); end
        total++; if (out_imm_type !== 3'd1) begin bad++; $display("[TB] FAIL addi_imm_type: got %0d want 1", out_imm_type); end
        total++; if (out_pc !== 32'h100) begin bad++; $display("[TB] FAIL addi_pc: got %h want 100", out_pc); end
        step();
        total++; if (count !== 2'd0 || out_valid !== 1'b0) begin bad++; $display("[TB] FAIL addi_drained: got count=%0d valid=%b want 0/0", count, out_valid); end
        wb_valid = 1'b1;
        wb_rd    = 5'd1;
        step();
        wb_valid = 1'b0;
    endtask

    task automatic test_full_wrap();
        logic [31:0] expect_head;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_inst   = 32'h0010_0013;
        step();
        in_inst   = 32'h0020_0013;
        step();
        in_inst   = 32'h0030_0013;
        #1;
        total++; if (count !== 2'd2 || in_ready !== 1'b0) begin bad++; $display("[TB] FAIL full_state: got count=%0d in_ready=%b want 2/0", count, in_ready); end
        step();
        total++; if (count !== 2'd2 || out_inst !== 32'h0010_0013) begin bad++; $display("[TB] FAIL full_blocked: got count=%0d head=%h want 2/00100013", count, out_inst); end
        out_ready = 1'b1;
        step();
        total++; if (count !== 2'd1 || out_inst !== 32'h0020_0013) begin bad++; $display("[TB] FAIL first_pop: got count=%0d head=%h want 1/00200013", count, out_inst); end
        step();
        total++; if (count !== 2'd1 || out_inst !== 32'h0030_0013) begin bad++; $display("[TB] FAIL third_push: got count=%0d head=%h want 1/00300013", count, out_inst); end
        for (int i = 0; i < 10; i++) begin
            expect_head = 32'h0000_0013 | (32'(i + 4) << 20);
            in_inst = expect_head;
            step();
            total++; if (count !== 2'd1 || out_inst !== expect_head || out_valid !== 1'b1)
                begin bad++; $display("[TB] FAIL wrap_%0d: got count=%0d head=%h valid=%b want 1/%h/1", i, count, out_inst, out_valid, expect_head); end
        end
        in_valid = 1'b0;
        step();
        total++; if (count !== 2'd0) begin bad++; $display("[TB] FAIL wrap_drain: got count=%0d want 0", count); end
    endtask

    task automatic test_raw();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_inst   = 32'hFFF0_0093;
        step();
        in_inst   = 32'h0010_8133;
        step();
        in_valid  = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0 || out_inst !== 32'h0010_8133) begin bad++; $display("[TB] FAIL raw_stall: got valid=%b head=%h want 0/00108133", out_valid, out_inst); end
        total++; if (out_rs1 !== 5'd1 || out_rs2 !== 5'd1 || out_rd !== 5'd2 || out_imm_type !== 3'd0)
            begin bad++; $display("[TB] FAIL add_fields: got rs1=%0d rs2=%0d rd=%0d type=%0d want 1/1/2/0", out_rs1, out_rs2, out_rd, out_imm_type); end
        step();
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL raw_hold: got %b want 0", out_valid); end
        wb_valid = 1'b1;
        wb_rd    = 5'd1;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL raw_no_bypass: got %b want 0", out_valid); end
        step();
        wb_valid = 1'b0;
        #1;
        total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL raw_release: got %b want 1", out_valid); end
        step();
        total++; if (count !== 2'd0) begin bad++; $display("[TB] FAIL raw_dispatched: got count=%0d want 0", count); end
        wb_valid = 1'b1;
        wb_rd    = 5'd2;
        step();
        wb_valid = 1'b0;
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_inst   = 32'h0010_0013;
        step();
        in_inst   = 32'h0020_0013;
        step();
        in_inst   = 32'h0030_0013;
        flush     = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL flush_valid_forced: got %b want 0", out_valid); end
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        total++; if (count !== 2'd0 || out_valid !== 1'b0 || out_inst !== 32'h0)
            begin bad++; $display("[TB] FAIL flush_full: got count=%0d valid=%b head=%h want 0/0/0", count, out_valid, out_inst); end
        in_valid = 1'b1;
        in_inst  = 32'h0010_0013;
        step();
        in_inst  = 32'h0030_0013;
        flush    = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL flush_push_ready: got %b want 1", in_ready); end
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        total++; if (count !== 2'd0 || out_valid !== 1'b0) begin bad++; $display("[TB] FAIL flush_drop_push: got count=%0d valid=%b want 0/0", count, out_valid); end
    endtask

    task automatic test_sb_saturate();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_inst   = 32'h0010_0293;
        for (int i = 0; i < 4; i++) step();
        in_valid = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0 || count !== 2'd1) begin bad++; $display("[TB] FAIL sat_stall: got valid=%b count=%0d want 0/1", out_valid, count); end
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL sat_hold: got %b want 0", out_valid); end
        sb_clear = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL sat_clear_same_cycle: got %b want 0", out_valid); end
        step();
        sb_clear = 1'b0;
        #1;
        total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL sat_clear_release: got %b want 1", out_valid); end
        step();
        total++; if (count !== 2'd0) begin bad++; $display("[TB] FAIL sat_dispatched: got count=%0d want 0", count); end
        wb_valid = 1'b1;
        wb_rd    = 5'd5;
        step();
        wb_valid = 1'b0;
    endtask

    task automatic test_illegal_ecall();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_inst   = 32'h0000_007F;
        step();
        in_inst   = 32'h0000_0073;
        step();
        in_valid  = 1'b0;
        #1;
        total++; if (out_illegal !== 1'b1 || out_rd_wen !== 1'b0 || out_valid !== 1'b1)
            begin bad++; $display("[TB] FAIL illegal_head: got ill=%b wen=%b valid=%b want 1/0/1", out_illegal, out_rd_wen, out_valid); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        #1;
        total++; if (out_ecall !== 1'b1 || out_illegal !== 1'b0 || out_rd_wen !== 1'b0 || out_imm_type !== 3'd1)
            begin bad++; $display("[TB] FAIL ecall_head: got ecall=%b ill=%b wen=%b type=%0d want 1/0/0/1", out_ecall, out_illegal, out_rd_wen, out_imm_type); end
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    task automatic test_immediates();
        logic [31:0] insts [5] = '{32'hFE20_AE23, 32'hFE00_0CE3, 32'h0010_006F, 32'h8000_01B7, 32'h3020_0073};
        logic [31:0] imms  [5] = '{32'hFFFF_FFFC, 32'hFFFF_FFF8, 32'h0000_0800, 32'h8000_0000, 32'h0000_0302};
        logic [2:0]  types [5] = '{3'd2, 3'd3, 3'd5, 3'd4, 3'd1};
        logic        wens  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_inst  = insts[i];
            step();
            in_valid = 1'b0;
            #1;
            total++; if (out_imm !== imms[i] || out_imm_type !== types[i] || out_rd_wen !== wens[i])
                begin bad++; $display("[TB] FAIL imm_%0d: got imm=%h type=%0d wen=%b want %h/%0d/%b", i, out_imm, out_imm_type, out_rd_wen, imms[i], types[i], wens[i]); end
            total++; if (out_mem_wen !== (i == 0) || out_branch !== (i == 1) || out_jump !== (i == 2) || out_mret !== (i == 4))
                begin bad++; $display("[TB] FAIL flags_%0d: got memw=%b br=%b jmp=%b mret=%b", i, out_mem_wen, out_branch, out_jump, out_mret); end
            flush = 1'b1;
            step();
            flush = 1'b0;
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_addi();
        test_full_wrap();
        test_raw();
        test_flush();
        test_sb_saturate();
        test_illegal_ecall();
        test_immediates();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
